// File: rtl/line_window_buffer.sv
// Streaming KxK sliding-window generator: K-1 circular line memories feed a
// KxK shift-register window, and only fully valid windows are emitted.
module line_window_buffer #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int K      = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       in_pixel,
    input  logic                    in_valid,
    input  logic                    in_sof,
    output logic                    in_ready,
    output logic [K*K*DATA_W-1:0]   out_window,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_eol,
    output logic                    out_eof
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_FIRST_OUT = COL_W'(K - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST_OUT = ROW_W'(K - 1);

    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              out_valid_q, out_valid_d;
    logic              out_eol_q, out_eol_d;
    logic              out_eof_q, out_eof_d;
    logic [DATA_W-1:0] win_q [K][K];
    logic [DATA_W-1:0] win_d [K][K];

    logic [DATA_W-1:0] line_mem [K-1][IMG_W];
    logic [DATA_W-1:0] col_vec  [K];

    logic              acc;
    logic [COL_W-1:0]  pix_col;
    logic [ROW_W-1:0]  pix_row;

    assign in_ready = !out_valid_q || out_ready;
    assign acc      = in_valid && in_ready;

    // A start-of-frame pixel is placed at (0,0) regardless of the counters.
    assign pix_col  = in_sof ? '0 : col_q;
    assign pix_row  = in_sof ? '0 : row_q;

    assign out_valid = out_valid_q;
    assign out_eol   = out_eol_q;
    assign out_eof   = out_eof_q;

    always_comb begin
        for (int j = 0; j < K - 1; j++) begin
            col_vec[j] = line_mem[j][pix_col];
        end
        col_vec[K-1] = in_pixel;
    end

    always_comb begin
        out_window = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                out_window[(r*K+c)*DATA_W +: DATA_W] = win_q[r][c];
            end
        end
    end

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        out_valid_d = out_valid_q;
        out_eol_d   = out_eol_q;
        out_eof_d   = out_eof_q;
        win_d       = win_q;

        if (acc) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][K-1] = col_vec[r];
            end

            if (pix_col == COL_LAST) begin
                col_d = '0;
                row_d = (pix_row == ROW_LAST) ? '0 : pix_row + ROW_W'(1);
            end else begin
                col_d = pix_col + COL_W'(1);
                row_d = pix_row;
            end

            // Windows that straddle a line wrap never reach this condition.
            out_valid_d = (pix_row >= ROW_FIRST_OUT) && (pix_col >= COL_FIRST_OUT);
            out_eol_d   = (pix_col == COL_LAST);
            out_eof_d   = (pix_col == COL_LAST) && (pix_row == ROW_LAST);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_eol_d   = 1'b0;
            out_eof_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_eol_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_eol_q   <= out_eol_d;
            out_eof_q   <= out_eof_d;
            win_q       <= win_d;
        end
    end

    // Line memories are left uncleared; lines above K-1 never produce output.
    always_ff @(posedge clk) begin
        if (acc && !rst) begin
            for (int j = 0; j < K - 2; j++) begin
                line_mem[j][pix_col] <= line_mem[j+1][pix_col];
            end
            line_mem[K-2][pix_col] <= in_pixel;
        end
    end

endmodule
